bsg_counter_up_batch_send: RTL and testbench

//  Producer-side partner of the loadable down counter: accumulates single-bit up events
//  (returned credits, freed slots) and sends the total as one batch over a valid/yumi port.
//  The consumer loads each batch with set_i, then decrements it with down_i.

---
 rtl/bsg_counter_up_batch_pkg.sv | 17 +
 rtl/bsg_counter_up_batch_send_if.sv | 22 ++
 rtl/bsg_counter_clear_up.sv | 22 ++
 rtl/bsg_counter_up_batch_send.sv | 119 +++++++++++
 tb/tb_bsg_counter_up_batch_send.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bsg_counter_up_batch_pkg.sv
// Shared types and helpers for the batching up-counter.
package bsg_counter_up_batch_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    e_idle  = 2'd0,
    e_accum = 2'd1,
    e_hold  = 2'd2
  } state_e;

  // Counter width able to hold 0..x-1, never less than one bit.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_counter_up_batch_send_if.sv
// Event input and batch valid/yumi port of the batching up-counter.
// BSG_COUNTER_UP_BATCH_FLUSH_EN adds the flush_i request line.
interface bsg_counter_up_batch_send_if #(
  parameter int unsigned width_p = 16
);

  logic               up_i;
  logic               yumi_i;
  logic               v_o;
  logic [width_p-1:0] count_o;
  logic               overflow_o;
`ifdef BSG_COUNTER_UP_BATCH_FLUSH_EN
  logic               flush_i;

  modport master (input up_i, yumi_i, flush_i, output v_o, count_o, overflow_o);
  modport slave  (output up_i, yumi_i, flush_i, input v_o, count_o, overflow_o);
`else
  modport master (input up_i, yumi_i, output v_o, count_o, overflow_o);
  modport slave  (output up_i, yumi_i, input v_o, count_o, overflow_o);
`endif

endinterface

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear takes precedence over up.
module bsg_counter_clear_up #(
  parameter int unsigned width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)      count_q <= '0;
    else if (clear_i) count_q <= '0;
    else if (up_i)    count_q <= count_q + width_p'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_counter_up_batch_send.sv
// Accumulates up events and ships them as batches over a valid/yumi port,
// on threshold or timeout (and on flush_i when BSG_COUNTER_UP_BATCH_FLUSH_EN).
module bsg_counter_up_batch_send
  import bsg_counter_up_batch_pkg::*;
#(
  parameter int unsigned width_p     = 16,
  parameter int unsigned threshold_p = 8,
  parameter int unsigned timeout_p   = 32
) (
  input logic                        clk_i,
  input logic                        reset_i,
  bsg_counter_up_batch_send_if.master bus
);

  localparam int unsigned TMR_W = safe_clog2(timeout_p);

  state_e             state_q, state_d;
  logic [width_p-1:0] accum_q, accum_d;
  logic [width_p-1:0] send_q, send_d;
  logic               v_q, v_d;
  logic               overflow_q, overflow_d;
  logic [TMR_W-1:0]   timer_cnt;

  logic flush, slot_free, trig, sat;
  logic xfer, timer_clr, timer_up;

`ifdef BSG_COUNTER_UP_BATCH_FLUSH_EN
  assign flush = bus.flush_i;
`else
  assign flush = 1'b0;
`endif

  assign slot_free = ~v_q | bus.yumi_i;
  assign sat       = &accum_q;
  assign trig      = (accum_q >= width_p'(threshold_p))
                   | (timer_cnt == TMR_W'(timeout_p - 1))
                   | flush;

  // Cycles spent accumulating the current batch; frozen while holding.
  bsg_counter_clear_up #(.width_p(TMR_W)) timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (timer_clr),
    .up_i    (timer_up),
    .count_o (timer_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_idle:  if (bus.up_i) state_d = e_accum;
      e_accum: if (trig) state_d = slot_free ? (bus.up_i ? e_accum : e_idle) : e_hold;
      e_hold:  if (slot_free) state_d = bus.up_i ? e_accum : e_idle;
      default: state_d = e_idle;
    endcase
  end

  always_comb begin
    xfer      = 1'b0;
    timer_clr = 1'b0;
    timer_up  = 1'b0;
    case (state_q)
      e_idle:  timer_clr = 1'b1;
      e_accum: begin
        xfer      = trig & slot_free;
        timer_clr = trig & slot_free;
        timer_up  = ~trig;
      end
      e_hold: begin
        xfer      = slot_free;
        timer_clr = slot_free;
      end
      default: timer_clr = 1'b1;
    endcase
  end

  // The transfer-cycle event always seeds the new batch, never the sent one.
  always_comb begin
    accum_d    = accum_q;
    send_d     = send_q;
    v_d        = v_q;
    overflow_d = overflow_q;
    if (xfer) begin
      accum_d = width_p'(bus.up_i);
      send_d  = accum_q;
      v_d     = 1'b1;
    end else begin
      if (bus.up_i & ~sat) accum_d = accum_q + width_p'(1);
      if (bus.up_i & sat)  overflow_d = 1'b1;
      if (bus.yumi_i)      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      accum_q    <= '0;
      send_q     <= '0;
      v_q        <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      accum_q    <= accum_d;
      send_q     <= send_d;
      v_q        <= v_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.v_o        = v_q;
  assign bus.count_o    = send_q;
  assign bus.overflow_o = overflow_q;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) bus.yumi_i |-> v_q);

endmodule

// File: tb/tb_bsg_counter_up_batch_send.sv
// Bench for bsg_counter_up_batch_send: directed scenarios plus random traffic
// checked against an event-level reference model and a conservation scoreboard.
module tb_bsg_counter_up_batch_send;
  import bsg_counter_up_batch_pkg::*;

  localparam int unsigned W   = 4;
  localparam int unsigned THR = 4;
  localparam int unsigned TO  = 32;
  localparam int          MAX = 15;
`ifdef BSG_COUNTER_UP_BATCH_FLUSH_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_counter_up_batch_send_if #(.width_p(W)) bus ();

  bsg_counter_up_batch_send #(
    .width_p(W), .threshold_p(THR), .timeout_p(TO)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending events, age of the pending batch, a "send wanted"
  // flag for a batch stalled behind an unaccepted one, and the outstanding batch.
  int m_accum, m_age, m_send;
  bit m_wait, m_v, m_ovf;
  int total_up, yumi_sum;

  task automatic model_reset();
    m_accum = 0; m_age = 0; m_send = 0;
    m_wait = 0; m_v = 0; m_ovf = 0;
    total_up = 0; yumi_sum = 0;
  endtask

  task automatic apply_reset(input bit up);
    rst = 1'b1;
    bus.up_i = up; bus.yumi_i = 1'b0;
`ifdef BSG_COUNTER_UP_BATCH_FLUSH_EN
    bus.flush_i = 1'b0;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of inputs and advance the model by the same cycle.
  task automatic step(input bit up, input bit yumi, input bit flush);
    bit slot, fire;
    bus.up_i = up; bus.yumi_i = yumi;
`ifdef BSG_COUNTER_UP_BATCH_FLUSH_EN
    bus.flush_i = flush;
`endif
    if (yumi) yumi_sum += int'(bus.count_o);
    total_up += int'(up);
    @(posedge clk);
    slot = !m_v || yumi;
    if (m_accum == 0) begin
      if (up) begin m_accum = 1; m_age = 0; end
      if (yumi) m_v = 0;
    end else begin
      fire = m_wait || (m_accum >= int'(THR)) || (m_age == int'(TO) - 1) || (FL_EN && flush);
      if (fire && slot) begin
        m_send = m_accum; m_v = 1; m_accum = int'(up); m_age = 0; m_wait = 0;
      end else begin
        if (yumi) m_v = 0;
        if (fire) m_wait = 1; else m_age++;
        if (up) begin
          if (m_accum == MAX) m_ovf = 1; else m_accum++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    n_cmp++; if (bus.v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v got %0b want 0", bus.v_o); end
    n_cmp++; if (bus.count_o !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", bus.overflow_o); end
    n_cmp++; if (dut.accum_q !== '0) begin n_fail++; $display("FAIL reset_accum got %0d want 0", dut.accum_q); end
    n_cmp++; if (dut.state_q !== e_idle) begin n_fail++; $display("FAIL reset_state got %0d want idle", dut.state_q); end
  endtask

  task automatic test_threshold();
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.v_o !== 1'b0) begin n_fail++; $display("FAIL thr_early_v got %0b want 0", bus.v_o); end
    n_cmp++; if (dut.accum_q !== W'(4)) begin n_fail++; $display("FAIL thr_accum4 got %0d want 4", dut.accum_q); end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.v_o !== 1'b1) begin n_fail++; $display("FAIL thr_v got %0b want 1", bus.v_o); end
    n_cmp++; if (bus.count_o !== W'(4)) begin n_fail++; $display("FAIL thr_count got %0d want 4", bus.count_o); end
    n_cmp++; if (dut.accum_q !== W'(1)) begin n_fail++; $display("FAIL thr_carry got %0d want 1", dut.accum_q); end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.v_o !== 1'b0) begin n_fail++; $display("FAIL thr_yumi_v got %0b want 0", bus.v_o); end
    n_cmp++; if (total_up !== yumi_sum + int'(dut.accum_q)) begin n_fail++;
      $display("FAIL thr_conserve got %0d want %0d", yumi_sum + int'(dut.accum_q), total_up); end
  endtask

  task automatic test_timeout();
    bit got = 0;
    int at = -1;
    apply_reset(1'b0);
    for (int i = 0; i < 100 && !got; i++) begin
      step(i < 3, 1'b0, 1'b0);
      if (bus.v_o === 1'b1) begin got = 1; at = i; end
    end
    n_cmp++; if (at !== 32) begin n_fail++; $display("FAIL tmo_cycle got %0d want 32", at); end
    n_cmp++; if (bus.count_o !== W'(3)) begin n_fail++; $display("FAIL tmo_count got %0d want 3", bus.count_o); end
    n_cmp++; if (dut.state_q !== e_idle) begin n_fail++; $display("FAIL tmo_state got %0d want idle", dut.state_q); end
    n_cmp++; if (dut.accum_q !== W'(m_accum)) begin n_fail++; $display("FAIL tmo_accum got %0d want %0d", dut.accum_q, m_accum); end
  endtask

  task automatic test_hold();
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (dut.state_q !== e_hold) begin n_fail++; $display("FAIL hold_state got %0d want hold", dut.state_q); end
    n_cmp++; if (bus.count_o !== W'(4)) begin n_fail++; $display("FAIL hold_count got %0d want 4", bus.count_o); end
    n_cmp++; if (dut.accum_q !== W'(6)) begin n_fail++; $display("FAIL hold_accum got %0d want 6", dut.accum_q); end
    step(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.v_o !== 1'b1) begin n_fail++; $display("FAIL b2b_v got %0b want 1", bus.v_o); end
    n_cmp++; if (bus.count_o !== W'(6)) begin n_fail++; $display("FAIL b2b_count got %0d want 6", bus.count_o); end
    n_cmp++; if (bus.count_o !== W'(m_send)) begin n_fail++; $display("FAIL b2b_model got %0d want %0d", bus.count_o, m_send); end
    n_cmp++; if (dut.accum_q !== W'(1)) begin n_fail++; $display("FAIL b2b_accum got %0d want 1", dut.accum_q); end
  endtask

  task automatic test_saturation();
    apply_reset(1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (dut.accum_q !== W'(MAX)) begin n_fail++; $display("FAIL sat_accum got %0d want 15", dut.accum_q); end
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got %0b want 1", bus.overflow_o); end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.count_o !== W'(MAX)) begin n_fail++; $display("FAIL sat_count got %0d want 15", bus.count_o); end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.v_o !== 1'b0) begin n_fail++; $display("FAIL sat_drain_v got %0b want 0", bus.v_o); end
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_fail++; $display("FAIL sat_sticky got %0b want 1", bus.overflow_o); end
    apply_reset(1'b0);
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %0b want 0", bus.overflow_o); end
  endtask

  task automatic test_reset_mid_batch();
    apply_reset(1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.v_o !== 1'b1 || dut.accum_q !== W'(3)) begin n_fail++;
      $display("FAIL mid_setup got v=%0b accum=%0d want v=1 accum=3", bus.v_o, dut.accum_q); end
    apply_reset(1'b1);
    n_cmp++; if (bus.v_o !== 1'b0) begin n_fail++; $display("FAIL mid_v got %0b want 0", bus.v_o); end
    n_cmp++; if (bus.count_o !== '0) begin n_fail++; $display("FAIL mid_count got %0d want 0", bus.count_o); end
    n_cmp++; if (dut.state_q !== e_idle) begin n_fail++; $display("FAIL mid_state got %0d want idle", dut.state_q); end
  endtask

`ifdef BSG_COUNTER_UP_BATCH_FLUSH_EN
  task automatic test_flush();
    apply_reset(1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.v_o !== 1'b1) begin n_fail++; $display("FAIL flush_v got %0b want 1", bus.v_o); end
    n_cmp++; if (bus.count_o !== W'(2)) begin n_fail++; $display("FAIL flush_count got %0d want 2", bus.count_o); end
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.v_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_v got %0b want 0", bus.v_o); end
  endtask
`endif

  task automatic test_random();
    bit up, yumi, flush;
    apply_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      up    = ($urandom_range(0, 9) < 6);
      yumi  = m_v && ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 19) == 0);
      step(up, yumi, flush);
      n_cmp++; if (bus.v_o !== m_v) begin n_fail++; $display("FAIL rnd_v cyc %0d got %0b want %0b", i, bus.v_o, m_v); end
      n_cmp++; if (bus.count_o !== W'(m_send)) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, bus.count_o, m_send); end
      n_cmp++; if (bus.overflow_o !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %0b want %0b", i, bus.overflow_o, m_ovf); end
      n_cmp++; if (dut.accum_q !== W'(m_accum)) begin n_fail++; $display("FAIL rnd_accum cyc %0d got %0d want %0d", i, dut.accum_q, m_accum); end
    end
    if (!m_ovf) begin
      n_cmp++;
      if (total_up !== yumi_sum + (bus.v_o ? int'(bus.count_o) : 0) + int'(dut.accum_q)) begin n_fail++;
        $display("FAIL rnd_conserve got %0d want %0d", yumi_sum + (bus.v_o ? int'(bus.count_o) : 0) + int'(dut.accum_q), total_up);
      end
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_timeout();
    test_hold();
    test_saturation();
    test_reset_mid_batch();
`ifdef BSG_COUNTER_UP_BATCH_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
